// File: rtl/alu_pkg.sv
// Shared op codes and sequencer state encoding for the
// register-file / ALU / write-back datapath.
package alu_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_SGT = 4'b1000;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_SRL = 4'b1101;
  localparam logic [3:0] OP_SLL = 4'b1110;
  localparam logic [3:0] OP_SRA = 4'b1111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    EXEC  = 2'd2,
    WRITE = 2'd3
  } state_t;

endpackage

// File: rtl/alu_op_legal.sv
// Combinational legality check for a 4-bit ALU op code.
// Shared with the future decoder.
module alu_op_legal
  import alu_pkg::*;
(
  input  logic [3:0] op,
  output logic       legal
);

  always_comb begin
    legal = 1'b0;
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT,
      OP_SGT, OP_NOR, OP_SRL, OP_SLL, OP_SRA:
        legal = 1'b1;
      default:
        legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// One-command-at-a-time controller for the register file,
// ALU and write-back mux; every output is a register.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_op,
  input  logic [REG_AW-1:0] cmd_rs,
  input  logic [REG_AW-1:0] cmd_rt,
  input  logic [REG_AW-1:0] cmd_rd,
  input  logic [4:0]        cmd_shamt,
  input  logic              cmd_imm_en,
  input  logic [DATA_W-1:0] cmd_imm,
  input  logic              cmd_we,
  output logic [REG_AW-1:0] rf_rr1,
  output logic [REG_AW-1:0] rf_rr2,
  output logic [REG_AW-1:0] rf_wr,
  output logic              rf_we,
  output logic [DATA_W-1:0] rf_wd,
  output logic              mux_sel,
  output logic [3:0]        alu_op,
  output logic [4:0]        alu_shamt,
  input  logic [DATA_W-1:0] alu_result,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_err,
  output logic [CNT_W-1:0]  retired_cnt
);

  state_t state;
  logic   we_q;
  logic   legal;

  alu_op_legal u_legal (
    .op    (cmd_op),
    .legal (legal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cmd_ready   <= 1'b1;
      we_q        <= 1'b0;
      rf_rr1      <= '0;
      rf_rr2      <= '0;
      rf_wr       <= '0;
      rf_we       <= 1'b0;
      rf_wd       <= '0;
      mux_sel     <= 1'b1;
      alu_op      <= '0;
      alu_shamt   <= '0;
      rsp_valid   <= 1'b0;
      rsp_result  <= '0;
      rsp_err     <= 1'b0;
      retired_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            rf_wr     <= cmd_rd;
            we_q      <= cmd_we;
            if (cmd_imm_en) begin
              state      <= WRITE;
              rf_we      <= cmd_we;
              mux_sel    <= 1'b0;
              rf_wd      <= cmd_imm;
              rsp_valid  <= 1'b1;
              rsp_result <= cmd_imm;
            end else if (legal) begin
              state     <= READ;
              rf_rr1    <= cmd_rs;
              rf_rr2    <= cmd_rt;
              alu_op    <= cmd_op;
              alu_shamt <= cmd_shamt;
              mux_sel   <= 1'b1;
            end else begin
              // illegal op: report immediately, never write
              state      <= WRITE;
              rsp_valid  <= 1'b1;
              rsp_err    <= 1'b1;
              rsp_result <= '0;
            end
          end
        end
        READ: begin
          state <= EXEC;
        end
        EXEC: begin
          state      <= WRITE;
          rf_we      <= we_q;
          rsp_valid  <= 1'b1;
          rsp_result <= alu_result;
        end
        WRITE: begin
          state       <= IDLE;
          cmd_ready   <= 1'b1;
          rf_we       <= 1'b0;
          rsp_valid   <= 1'b0;
          rsp_err     <= 1'b0;
          retired_cnt <= retired_cnt + CNT_W'(1);
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: register file + ALU around the
// DUT, directed steps then random commands vs. a reference model.
module tb_alu_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic [4:0]  cmd_rs;
  logic [4:0]  cmd_rt;
  logic [4:0]  cmd_rd;
  logic [4:0]  cmd_shamt;
  logic        cmd_imm_en;
  logic [31:0] cmd_imm;
  logic        cmd_we;
  logic [4:0]  rf_rr1;
  logic [4:0]  rf_rr2;
  logic [4:0]  rf_wr;
  logic        rf_we;
  logic [31:0] rf_wd;
  logic        mux_sel;
  logic [3:0]  alu_op;
  logic [4:0]  alu_shamt;
  logic [31:0] alu_result;
  logic        rsp_valid;
  logic [31:0] rsp_result;
  logic        rsp_err;
  logic [1:0]  retired_cnt;

  int total = 0;
  int bad = 0;
  int ref_cnt = 0;

  logic [31:0] env_rf [32] = '{default: '0};
  logic [31:0] ref_rf [32] = '{default: '0};

  alu_cmd_sequencer #(
    .DATA_W (32),
    .REG_AW (5),
    .CNT_W  (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_rs      (cmd_rs),
    .cmd_rt      (cmd_rt),
    .cmd_rd      (cmd_rd),
    .cmd_shamt   (cmd_shamt),
    .cmd_imm_en  (cmd_imm_en),
    .cmd_imm     (cmd_imm),
    .cmd_we      (cmd_we),
    .rf_rr1      (rf_rr1),
    .rf_rr2      (rf_rr2),
    .rf_wr       (rf_wr),
    .rf_we       (rf_we),
    .rf_wd       (rf_wd),
    .mux_sel     (mux_sel),
    .alu_op      (alu_op),
    .alu_shamt   (alu_shamt),
    .alu_result  (alu_result),
    .rsp_valid   (rsp_valid),
    .rsp_result  (rsp_result),
    .rsp_err     (rsp_err),
    .retired_cnt (retired_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic is_legal(input logic [3:0] op);
    return op inside {4'h0, 4'h1, 4'h2, 4'h6, 4'h7,
                      4'h8, 4'hC, 4'hD, 4'hE, 4'hF};
  endfunction

  function automatic logic [31:0] alu_fn(input logic [3:0] op,
      input logic [31:0] a, input logic [31:0] b,
      input logic [4:0] sh);
    case (op)
      4'h0: return a & b;
      4'h1: return a | b;
      4'h2: return a + b;
      4'h6: return a - b;
      4'h7: return {31'b0, $signed(a) < $signed(b)};
      4'h8: return {31'b0, $signed(a) > $signed(b)};
      4'hC: return ~(a | b);
      4'hD: return b >> sh;
      4'hE: return b << sh;
      4'hF: return $unsigned($signed(b) >>> sh);
      default: return 32'h0;
    endcase
  endfunction

  // datapath around the sequencer
  assign alu_result = alu_fn(alu_op, env_rf[rf_rr1],
                             env_rf[rf_rr2], alu_shamt);

  always @(posedge clk)
    if (rf_we) env_rf[rf_wr] <= mux_sel ? alu_result : rf_wd;

  function automatic int rf_diff();
    int d = 0;
    for (int i = 0; i < 32; i++)
      if (env_rf[i] !== ref_rf[i]) d++;
    return d;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [4:0] rs,
      input logic [4:0] rt, input logic [4:0] rd,
      input logic [4:0] sh, input logic ie,
      input logic [31:0] imm, input logic we);
    cmd_op     = op;
    cmd_rs     = rs;
    cmd_rt     = rt;
    cmd_rd     = rd;
    cmd_shamt  = sh;
    cmd_imm_en = ie;
    cmd_imm    = imm;
    cmd_we     = we;
  endtask

  task automatic scramble();
    drive(4'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
          5'($urandom), 1'($urandom), $urandom, 1'($urandom));
  endtask

  // entered and left at a negedge with the DUT idle
  task automatic run_cmd(input logic [3:0] op, input logic [4:0] rs,
      input logic [4:0] rt, input logic [4:0] rd,
      input logic [4:0] sh, input logic ie,
      input logic [31:0] imm, input logic we);
    int n;
    logic lg;
    logic [31:0] res;
    int exp_lat;
    logic exp_we;
    lg = is_legal(op);
    if (ie) res = imm;
    else if (lg) res = alu_fn(op, ref_rf[rs], ref_rf[rt], sh);
    else res = 32'h0;
    exp_lat = (ie || !lg) ? 1 : 3;
    exp_we = we && (ie || lg);
    n = 0;
    while (!cmd_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("ready_idle", 32'(cmd_ready), 1);
    drive(op, rs, rt, rd, sh, ie, imm, we);
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    scramble();
    n = 0;
    do begin
      @(negedge clk);
      n++;
      chk("ready_busy", 32'(cmd_ready), 0);
      chk("we_only_write", 32'(rf_we), 32'(rsp_valid && exp_we));
      if (n == 1 && exp_lat == 3) begin
        chk("rr1", 32'(rf_rr1), 32'(rs));
        chk("rr2", 32'(rf_rr2), 32'(rt));
        chk("alu_op", 32'(alu_op), 32'(op));
        chk("alu_shamt", 32'(alu_shamt), 32'(sh));
        chk("mux_read", 32'(mux_sel), 1);
      end
    end while (!rsp_valid && n < 8);
    chk("latency", n, exp_lat);
    chk("rsp_err", 32'(rsp_err), 32'(!(ie || lg)));
    chk("rsp_result", rsp_result, res);
    if (exp_we) chk("rf_wr", 32'(rf_wr), 32'(rd));
    if (ie || lg) chk("mux_sel", 32'(mux_sel), 32'(!ie));
    if (ie) chk("rf_wd", rf_wd, imm);
    if (exp_we) ref_rf[rd] = res;
    ref_cnt++;
    @(negedge clk);
    chk("rsp_drop", 32'(rsp_valid), 0);
    chk("rf_state", rf_diff(), 0);
    chk("retired", 32'(retired_cnt), 32'(ref_cnt % 4));
  endtask

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b1;
    drive(4'h2, 5'd1, 5'd2, 5'd3, 5'd4, 1'b1, 32'h1234, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(cmd_ready), 1);
    chk("rst_we", 32'(rf_we), 0);
    chk("rst_rsp", 32'(rsp_valid), 0);
    chk("rst_err", 32'(rsp_err), 0);
    chk("rst_mux", 32'(mux_sel), 1);
    chk("rst_rr1", 32'(rf_rr1), 0);
    chk("rst_wr", 32'(rf_wr), 0);
    chk("rst_wd", rf_wd, 0);
    chk("rst_op", 32'(alu_op), 0);
    chk("rst_res", rsp_result, 0);
    chk("rst_cnt", 32'(retired_cnt), 0);
    rst = 1'b0;
    cmd_valid = 1'b0;
    @(negedge clk);

    run_cmd(4'h0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 32'hFFFF_FFFE, 1'b1);
    chk("r0_imm", env_rf[0], 32'hFFFF_FFFE);
    run_cmd(4'h0, 5'd0, 5'd0, 5'd31, 5'd0, 1'b1, 32'd1300, 1'b1);
    run_cmd(4'h2, 5'd0, 5'd31, 5'd3, 5'd0, 1'b0, 32'h0, 1'b1);
    chk("add_r3", env_rf[3], 32'd1298);
    run_cmd(4'h6, 5'd3, 5'd0, 5'd4, 5'd0, 1'b0, 32'h0, 1'b1);
    chk("sub_r4", env_rf[4], 32'd1300);
    run_cmd(4'h3, 5'd1, 5'd2, 5'd5, 5'd0, 1'b0, 32'h0, 1'b1);
    run_cmd(4'h2, 5'd1, 5'd2, 5'd6, 5'd0, 1'b0, 32'h0, 1'b0);

    // three ADDs r31 += r31 with cmd_valid held high
    drive(4'h2, 5'd31, 5'd31, 5'd31, 5'd0, 1'b0, 32'h0, 1'b1);
    cmd_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      chk("b2b_ready", 32'(cmd_ready), 32'(i % 4 == 0));
      chk("b2b_we", 32'(rf_we), 32'(i % 4 == 3));
      if (i == 9) cmd_valid = 1'b0;
      @(negedge clk);
    end
    for (int k = 0; k < 3; k++) ref_rf[31] = ref_rf[31] * 2;
    ref_cnt += 3;
    chk("b2b_r31", env_rf[31], 32'd10400);
    chk("b2b_rf", rf_diff(), 0);
    chk("b2b_cnt", 32'(retired_cnt), 32'(ref_cnt % 4));

    // reset during EXEC of an SRA
    drive(4'hF, 5'd0, 5'd0, 5'd7, 5'd2, 1'b0, 32'h0, 1'b1);
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("sra_shamt", 32'(alu_shamt), 2);
    @(negedge clk);
    rst = 1'b1;
    cmd_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cmd_valid = 1'b0;
    ref_cnt = 0;
    chk("mid_we", 32'(rf_we), 0);
    chk("mid_rsp", 32'(rsp_valid), 0);
    chk("mid_ready", 32'(cmd_ready), 1);
    chk("mid_op", 32'(alu_op), 0);
    chk("mid_cnt", 32'(retired_cnt), 0);
    @(negedge clk);
    chk("mid_nowrite", rf_diff(), 0);
    chk("mid_rsp2", 32'(rsp_valid), 0);

    for (int k = 0; k < 5; k++)
      run_cmd(4'($urandom), 5'($urandom), 5'($urandom),
              5'($urandom), 5'($urandom), 1'b1, $urandom, 1'b1);
    chk("wrap_cnt", 32'(retired_cnt), 1);

    for (int k = 0; k < 40; k++)
      run_cmd(4'($urandom), 5'($urandom), 5'($urandom),
              5'($urandom), 5'($urandom),
              $urandom_range(0, 3) == 0,
              $urandom, $urandom_range(0, 4) != 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
Multi-cycle controller that sequences the register-file / ALU / write-back-mux datapath, one command at a time. Accepts a command (ALU op or immediate load) over a valid/ready handshake. Drives register-file read addresses, ALU op and shift count, mux select and write enable. Reports each completed command with a one-cycle response pulse. Sits between the future instruction-decode stage and the existing datapath.

Parameters:
DATA_W, 32, datapath word width (register file / ALU / mux width).
REG_AW, 5, register address width (32 registers).
CNT_W, 16, width of retired-command counter.

Ports:
clk  in  1  single clock; all state updates on posedge.
rst  in  1  synchronous reset, active-high.
cmd_valid  in  1  command offered.
cmd_ready  out  1  sequencer can accept; high only in IDLE.
cmd_op  in  4  ALU op code.
cmd_rs  in  REG_AW  source A register.
cmd_rt  in  REG_AW  source B register.
cmd_rd  in  REG_AW  destination register.
cmd_shamt  in  5  shift count.
cmd_imm_en  in  1  1 = write cmd_imm to rd; ALU bypassed.
cmd_imm  in  DATA_W  immediate data.
cmd_we  in  1  0 = compute only, no register write.
rf_rr1  out  REG_AW  register-file read address 1.
rf_rr2  out  REG_AW  register-file read address 2.
rf_wr  out  REG_AW  register-file write address.
rf_we  out  1  register-file write enable.
rf_wd  out  DATA_W  external write data (mux input 0).
mux_sel  out  1  0 = rf_wd, 1 = ALU result.
alu_op  out  4  ALU op.
alu_shamt  out  5  ALU shift count.
alu_result  in  DATA_W  combinational ALU output.
rsp_valid  out  1  one-cycle completion pulse.
rsp_result  out  DATA_W  ALU result or immediate of completed command.
rsp_err  out  1  with rsp_valid: illegal op, nothing written.
retired_cnt  out  CNT_W  count of completed commands; includes errors.

Behaviour:
- Legal ops: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, SGT 1000, NOR 1100, SRL 1101, SLL 1110, SRA 1111. All other codes are illegal.
- All outputs are registered.
- Reset values: state IDLE, cmd_ready=1, rf_we=0, rsp_valid=0, rsp_err=0, mux_sel=1. All address, data, op, shamt, result and counter outputs are 0.
- Command capture: command fields are latched at the edge where cmd_valid && cmd_ready. They are held stable in internal registers until the command returns to IDLE.
- FSM transitions:
  - IDLE, no command: stay in IDLE.
  - IDLE, command accepted, imm_en=1: go to WRITE.
  - IDLE, command accepted, imm_en=0 and legal op: go to READ.
  - IDLE, command accepted, imm_en=0 and illegal op: go to WRITE with error flag set.
  - READ: drive rf_rr1=rs, rf_rr2=rt, alu_op, alu_shamt, mux_sel=1. Go to EXEC.
  - EXEC: keep the same outputs. Capture alu_result into result register at the cycle end. Go to WRITE.
  - WRITE:
    - rf_we = cmd_we && !err.
    - rf_wr=rd.
    - Immediate command: mux_sel=0, rf_wd=imm.
    - ALU command: mux_sel=1, ALU inputs still held.
    - rsp_valid=1, rsp_result = result (or imm); rsp_err = err.
    - Register file commits on the edge that ends WRITE.
    - Go to IDLE.
- Latency from accept edge:
  - ALU command: 3 cycles to the write commit; rsp_valid in cycle 3.
  - Immediate or illegal command: rsp_valid in cycle 1.
- Throughput: next command accepted in the IDLE cycle after WRITE. This gives no read-after-write hazard (write commits before the next READ).
- cmd_ready is 0 in READ, EXEC and WRITE. cmd_valid is ignored there. cmd_* may change freely while not ready.
- rf_we is high for exactly one cycle per writing command and is never high outside WRITE.
- Writes to register 0 are allowed; register 0 is not hardwired to zero.
- Illegal op: rsp_err=1, rf_we=0, rsp_result=0, counter still increments.
- retired_cnt increments on every rsp_valid and wraps modulo 2^CNT_W.
- Reset mid-operation (any state): next state IDLE, the in-flight command is dropped with no write and no rsp_valid. Reset wins over a simultaneous cmd_valid.

Decomposition:
- Shared package alu_pkg holds the 4-bit op code constants above and the FSM state enum (IDLE, READ, EXEC, WRITE).
- One sub-module, alu_op_legal: combinational op-code legality check, reusable by the future decoder.

Test Plan:
- Reset: assert rst 2 cycles with cmd_valid=1 -> all outputs at reset values, no rf_we, retired_cnt=0.
- Immediate write: imm_en=1, rd=0, imm=-2, we=1 -> next cycle rf_we=1, rf_wr=0, mux_sel=0, rf_wd=-2, rsp_valid=1, rsp_result=-2.
- ALU ADD: r0=-2, r31=1300; op=0010, rs=0, rt=31, rd=3 -> READ/EXEC drive rr1=0, rr2=31. WRITE: rf_we=1, rf_wr=3, mux_sel=1, rsp_result=1298. Follow-up SUB r3-r0 reads 1300.
- Illegal op 0011 -> one cycle later rsp_valid=1, rsp_err=1, rf_we=0. retired_cnt increments.
- Back-to-back: cmd_valid held high with three ADDs -> cmd_ready pattern 1,0,0,0 repeats. Exactly 3 rf_we pulses, 4 cycles apart.
- Reset asserted during EXEC of SRA (shamt=2) -> no rf_we, no rsp_valid, IDLE next cycle. With CNT_W=2, 5 commands leave retired_cnt=1.
